// File: rtl/cpu_mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port memory with a fixed
// number of wait states. Each access runs IDLE -> ACCESS -> DONE -> IDLE.
module cpu_mem_arbiter #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  gnt
);

    localparam int CW = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  last_q, last_d;
    logic                  ack0_q, ack0_d;
    logic                  ack1_q, ack1_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
    logic                  mem_en_q, mem_en_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  busy_q, busy_d;
    logic                  gnt_q, gnt_d;
    logic                  sel;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        ack0_d      = ack0_q;
        ack1_d      = ack1_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        busy_d      = busy_q;
        gnt_d       = gnt_q;
        // On a tie the requester not served last wins; a lone requester always wins.
        sel         = (req0 && req1) ? ~last_q : req1;

        case (state_q)
            S_IDLE: begin
                ack0_d   = 1'b0;
                ack1_d   = 1'b0;
                mem_en_d = 1'b0;
                busy_d   = 1'b0;
                if (req0 || req1) begin
                    mem_we_d    = sel ? we1    : we0;
                    mem_addr_d  = sel ? addr1  : addr0;
                    mem_wdata_d = sel ? wdata1 : wdata0;
                    mem_en_d    = 1'b1;
                    busy_d      = 1'b1;
                    gnt_d       = sel;
                    last_d      = sel;
                    cnt_d       = CW'(WAIT_STATES);
                    state_d     = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (gnt_q) begin
                        ack1_d = 1'b1;
                        if (!mem_we_q) rdata1_d = mem_rdata;
                    end else begin
                        ack0_d = 1'b1;
                        if (!mem_we_q) rdata0_d = mem_rdata;
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Dead cycle so the acked requester can drop req before re-arbitration.
                ack0_d  = 1'b0;
                ack1_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            last_q      <= 1'b1;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            gnt_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            gnt_q       <= gnt_d;
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign gnt       = gnt_q;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Scoreboard bench for cpu_mem_arbiter: directed requests push expected completions,
// a negedge monitor checks memory strobes and acks against the queue head.
module tb_cpu_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int WS = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1, mem_en, mem_we, busy, gnt;
    logic [DW-1:0] rdata0, rdata1, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    // Second instance with zero wait states
    logic          req0_z, req1_z, we0_z, we1_z;
    logic [AW-1:0] addr0_z, addr1_z;
    logic [DW-1:0] wdata0_z, wdata1_z;
    logic          ack0_z, ack1_z, mem_en_z, mem_we_z, busy_z, gnt_z;
    logic [DW-1:0] rdata0_z, rdata1_z, mem_wdata_z, mem_rdata_z;
    logic [AW-1:0] mem_addr_z;

    // Memory contents: byte = addr[7:0] ^ addr[15:8] ^ 8'hAF
    function automatic logic [DW-1:0] mem_model(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hAF;
    endfunction
    assign mem_rdata   = mem_model(mem_addr);
    assign mem_rdata_z = mem_model(mem_addr_z);

    cpu_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(WS)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .gnt(gnt)
    );

    cpu_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(0)) dut_z (
        .clk(clk), .rst(rst),
        .req0(req0_z), .req1(req1_z), .we0(we0_z), .we1(we1_z),
        .addr0(addr0_z), .addr1(addr1_z), .wdata0(wdata0_z), .wdata1(wdata1_z),
        .ack0(ack0_z), .ack1(ack1_z), .rdata0(rdata0_z), .rdata1(rdata1_z),
        .mem_en(mem_en_z), .mem_we(mem_we_z), .mem_addr(mem_addr_z),
        .mem_wdata(mem_wdata_z), .mem_rdata(mem_rdata_z),
        .busy(busy_z), .gnt(gnt_z)
    );

    typedef struct {
        logic          port;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] r0;
        logic [DW-1:0] r1;
    } exp_t;

    exp_t    exp_q[$];
    exp_t    mon_e;
    int      ack_cyc[$];
    int      n_chk = 0;
    int      n_fail = 0;
    int      cyc = 0;
    int      en_rise = 0;
    logic    en_prev = 1'b0;
    logic [DW-1:0] m_r0, m_r1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: memory strobes must match the pending access; every ack retires one entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_en) begin
                if (!en_prev) en_rise = cyc;
                if (exp_q.size() > 0) begin
                    chk("mem_addr", 32'(mem_addr), 32'(exp_q[0].addr));
                    chk("mem_we", 32'(mem_we), 32'(exp_q[0].we));
                    if (exp_q[0].we) chk("mem_wdata", 32'(mem_wdata), 32'(exp_q[0].wdata));
                    chk("gnt_active", 32'(gnt), 32'(exp_q[0].port));
                    chk("busy_active", 32'(busy), 1);
                end else begin
                    chk("unexpected_mem_en", 32'(mem_en), 0);
                end
            end
            if (ack0 || ack1) begin
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chk("ack_port", 32'(ack1), 32'(mon_e.port));
                    chk("ack_both", 32'(ack0 & ack1), 0);
                    chk("gnt_at_ack", 32'(gnt), 32'(mon_e.port));
                    chk("latency", 32'(cyc - en_rise), 32'(WS + 1));
                    chk("rdata0", 32'(rdata0), 32'(mon_e.r0));
                    chk("rdata1", 32'(rdata1), 32'(mon_e.r1));
                    ack_cyc.push_back(cyc);
                end else begin
                    chk("unexpected_ack", 32'(ack0 | ack1), 0);
                end
            end
        end
        en_prev = mem_en;
    end

    task automatic push_exp(input logic p, input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, input logic [DW-1:0] r0, input logic [DW-1:0] r1);
        exp_t e;
        e.port = p; e.we = we; e.addr = a; e.wdata = wd; e.r0 = r0; e.r1 = r1;
        exp_q.push_back(e);
    endtask

    task automatic wait_acks(input int n, input bit drop);
        int got = 0;
        for (int i = 0; i < 60 * n && got < n; i++) begin
            @(posedge clk); #1;
            if (ack0) begin got++; if (drop) req0 = 1'b0; end
            if (ack1) begin got++; if (drop) req1 = 1'b0; end
        end
        if (got < n) chk("ack_timeout", 32'(got), 32'(n));
    endtask

    // Single access; inputs are scrambled one cycle in to show the grant latched them.
    task automatic do_req(input logic p, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic [DW-1:0] rd_exp);
        if (!we) begin
            if (p) m_r1 = rd_exp; else m_r0 = rd_exp;
        end
        push_exp(p, we, a, wd, m_r0, m_r1);
        if (p) begin we1 = we; addr1 = a; wdata1 = wd; req1 = 1'b1; end
        else   begin we0 = we; addr0 = a; wdata0 = wd; req0 = 1'b1; end
        @(posedge clk); #1;
        if (p) begin we1 = ~we; addr1 = ~a; wdata1 = ~wd; end
        else   begin we0 = ~we; addr0 = ~a; wdata0 = ~wd; end
        wait_acks(1, 1'b1);
        @(posedge clk); #1;
        chk("done_busy", 32'(busy), 0);
        chk("done_ack", 32'({ack1, ack0}), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        req0_z = 0; req1_z = 0; we0_z = 0; we1_z = 0;
        addr0_z = '0; addr1_z = '0; wdata0_z = '0; wdata1_z = '0;
        m_r0 = '0; m_r1 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        chk("rst_ack", 32'({ack1, ack0}), 0);
        chk("rst_rdata", 32'({rdata1, rdata0}), 0);
        chk("rst_busy_gnt", 32'({busy, gnt}), 0);

        // Idle with no requests
        repeat (2) @(posedge clk);
        #1;
        chk("idle_mem_en", 32'(mem_en), 0);
        chk("idle_busy", 32'(busy), 0);

        do_req(1'b0, 1'b0, 16'h2329, 8'h00, 8'hA5);  // read, 0x29^0x23^0xAF = A5
        do_req(1'b1, 1'b1, 16'h9001, 8'h5C, 8'h00);  // write, rdata1 stays 00
        do_req(1'b1, 1'b0, 16'h1234, 8'h00, 8'h89);  // read, 0x34^0x12^0xAF = 89
        do_req(1'b0, 1'b1, 16'h4000, 8'h77, 8'h00);  // write, rdata0 stays A5

        // Tie out of reset: grants 0,1,0,1 spaced WS+3 cycles
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst2_rdata", 32'({rdata1, rdata0}), 0);
        chk("rst2_gnt", 32'(gnt), 0);
        m_r0 = '0; m_r1 = '0;
        we0 = 0; addr0 = 16'h0100; we1 = 0; addr1 = 16'h0200;
        req0 = 1'b1; req1 = 1'b1;
        push_exp(1'b0, 1'b0, 16'h0100, 8'h00, 8'hAE, 8'h00);
        push_exp(1'b1, 1'b0, 16'h0200, 8'h00, 8'hAE, 8'hAD);
        push_exp(1'b0, 1'b0, 16'h0100, 8'h00, 8'hAE, 8'hAD);
        push_exp(1'b1, 1'b0, 16'h0200, 8'h00, 8'hAE, 8'hAD);
        ack_cyc.delete();
        rst = 1'b0;
        wait_acks(4, 1'b0);
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("tie_ack_count", 32'(ack_cyc.size()), 4);
        if (ack_cyc.size() == 4)
            for (int i = 0; i < 3; i++) chk("tie_ack_spacing", 32'(ack_cyc[i+1] - ack_cyc[i]), 32'(WS + 3));

        // Reset on the second ACCESS cycle aborts without ack; requester 0 wins afterwards
        we0 = 0; addr0 = 16'h0300; req0 = 1'b1;
        push_exp(1'b0, 1'b0, 16'h0300, 8'h00, 8'hAE, 8'hAD);
        @(posedge clk); #1;
        chk("abort_mem_en_on", 32'(mem_en), 1);
        @(posedge clk); #1;
        rst = 1'b1; req1 = 1'b1;
        @(posedge clk); #1;
        chk("abort_mem_en", 32'(mem_en), 0);
        chk("abort_ack", 32'({ack1, ack0}), 0);
        chk("abort_busy", 32'(busy), 0);
        exp_q.delete();
        push_exp(1'b0, 1'b0, 16'h0300, 8'h00, 8'hAC, 8'h00);
        push_exp(1'b1, 1'b0, 16'h0200, 8'h00, 8'hAC, 8'hAD);
        rst = 1'b0;
        wait_acks(2, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        // Zero wait states: one ACCESS cycle, ack one cycle after sampling, 3-cycle occupancy
        req0_z = 1'b1;
        @(posedge clk); #1;
        chk("z_mem_en_on", 32'(mem_en_z), 1);
        chk("z_mem_addr", 32'(mem_addr_z), 0);
        chk("z_ack_early", 32'(ack0_z), 0);
        @(posedge clk); #1;
        chk("z_ack0", 32'(ack0_z), 1);
        chk("z_mem_en_off", 32'(mem_en_z), 0);
        chk("z_rdata0", 32'(rdata0_z), 32'h0AF);
        @(posedge clk); #1;
        chk("z_done_busy", 32'(busy_z), 0);
        chk("z_done_ack", 32'(ack0_z), 0);
        @(posedge clk); #1;
        chk("z_regrant", 32'(mem_en_z), 1);
        @(posedge clk); #1;
        chk("z_ack0_again", 32'(ack0_z), 1);
        chk("z_ack1", 32'(ack1_z), 0);
        req0_z = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
